// File: rtl/divisor_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divisor_pkg;

  localparam int ANCHO = 16;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] N_PASOS = 5'd16;
  localparam logic [ANCHO-1:0] COCIENTE_DIV_CERO = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only if it is non-negative.
module divisor_paso
  import divisor_pkg::*;
(
  input  logic [ANCHO:0]   i_rem,
  input  logic             i_bit,
  input  logic [ANCHO-1:0] i_dsr,
  output logic [ANCHO:0]   o_rem,
  output logic             o_q
);

  logic [ANCHO+1:0] w_shift;
  logic [ANCHO+1:0] w_diff;

  // Trial subtraction; the extra top bit acts as the borrow/sign.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_dsr};
    o_q     = ~w_diff[ANCHO+1];
    o_rem   = o_q ? w_diff[ANCHO:0] : w_shift[ANCHO:0];
  end

endmodule

// File: rtl/divisor_secuencial.sv
// 16-bit sequential restoring divider, one quotient bit per clock.
// Optional signed mode is enabled by defining DIVISOR_SIGNO_EN, which adds
// the con_signo input; magnitudes are divided unsigned and signs fixed on
// the final step so signed operation costs no extra cycles.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 16 restoring steps in progress (busy = 1)
// DONE  | results valid for one cycle (done = 1); start accepted here too
module divisor_secuencial
  import divisor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             busy,
  output logic             done,
  output logic             div_cero
`ifdef DIVISOR_SIGNO_EN
  ,
  input  logic             con_signo
`endif
);

  estado_t          r_estado;
  logic [CNT_W-1:0] r_cnt;
  logic [ANCHO-1:0] r_dvd;   // dividend bits shift out, quotient bits shift in
  logic [ANCHO-1:0] r_dsr;
  logic [ANCHO:0]   r_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signo;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [ANCHO-1:0] w_a_mag;
  logic [ANCHO-1:0] w_b_mag;
  logic [ANCHO:0]   w_rem_nxt;
  logic             w_q_bit;
  logic [ANCHO-1:0] w_quo_nxt;

`ifdef DIVISOR_SIGNO_EN
  assign w_signo = con_signo;
`else
  assign w_signo = 1'b0;
`endif

  // Operand magnitudes and signs, taken straight from the inputs at accept.
  always_comb begin
    w_a_neg   = w_signo & A[ANCHO-1];
    w_b_neg   = w_signo & B[ANCHO-1];
    w_a_mag   = w_a_neg ? (~A + 16'd1) : A;
    w_b_mag   = w_b_neg ? (~B + 16'd1) : B;
    w_quo_nxt = {r_dvd[ANCHO-2:0], w_q_bit};
  end

  divisor_paso u_paso (
    .i_rem (r_rem),
    .i_bit (r_dvd[ANCHO-1]),
    .i_dsr (r_dsr),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  // Control FSM, iteration counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_cero <= 1'b0;
    end else begin
      case (r_estado)
        IDLE, DONE: begin
          if (start) begin
            if (B == '0) begin
              r_estado <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cociente <= COCIENTE_DIV_CERO;
              residuo  <= A;
              div_cero <= 1'b1;
            end else begin
              r_estado <= CALC;
              busy     <= 1'b1;
              done     <= 1'b0;
              r_cnt    <= N_PASOS;
              r_rem    <= '0;
              r_dvd    <= w_a_mag;
              r_dsr    <= w_b_mag;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
            end
          end else begin
            r_estado <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo_nxt;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_estado <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cociente <= r_neg_q ? (~w_quo_nxt + 16'd1) : w_quo_nxt;
            residuo  <= r_neg_r ? (~w_rem_nxt[ANCHO-1:0] + 16'd1)
                                : w_rem_nxt[ANCHO-1:0];
            div_cero <= 1'b0;
          end
        end
        default: begin
          r_estado <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: vector table plus corner sequences.
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] cociente;
  logic [15:0] residuo;
  logic        busy;
  logic        done;
  logic        div_cero;
`ifdef DIVISOR_SIGNO_EN
  logic        con_signo = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divisor_secuencial dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .cociente (cociente),
    .residuo  (residuo),
    .busy     (busy),
    .done     (done),
    .div_cero (div_cero)
`ifdef DIVISOR_SIGNO_EN
    ,
    .con_signo(con_signo)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one start at a negedge and sample at negedges until done.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'h5A5A; B = 16'h0003;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    int lat, bc;
    run_div(v.a, v.b, lat, bc);
    chk({tag, "_lat"}, lat, (v.b == 0) ? 1 : 17);
    chk({tag, "_busy_cycles"}, bc, (v.b == 0) ? 0 : 16);
    chk({tag, "_q"}, cociente, v.q);
    chk({tag, "_r"}, residuo, v.r);
    chk({tag, "_dz"}, div_cero, v.dz);
    chk({tag, "_busy_in_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_q"}, cociente, v.q);
    chk({tag, "_hold_r"}, residuo, v.r);
  endtask

  initial begin
    int lat, bc, n;
    vecs[0] = '{16'd100,   16'd7,      16'd14,    16'd2,   1'b0};
    vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,   1'b0};
    vecs[2] = '{16'd3,     16'hFFFF,   16'd0,     16'd3,   1'b0};
    vecs[3] = '{16'd5,     16'd0,      16'hFFFF,  16'd5,   1'b1};
    vecs[4] = '{16'd9,     16'd3,      16'd3,     16'd0,   1'b0};
    vecs[5] = '{16'd0,     16'd5,      16'd0,     16'd0,   1'b0};
    vecs[6] = '{16'd12345, 16'd123,    16'd100,   16'd45,  1'b0};
    vecs[7] = '{16'd65535, 16'd256,    16'd255,   16'd255, 1'b0};
    vecs[8] = '{16'd7,     16'd9,      16'd0,     16'd7,   1'b0};
    vecs[9] = '{16'd1000,  16'd10,     16'd100,   16'd0,   1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", cociente, 0);
    chk("rst_r", residuo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_cero, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      check_vec($sformatf("vec%0d", i), vecs[i]);

    // Second start mid-CALC must be ignored.
    @(negedge clk);
    A = 16'd100; B = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 16'd50; B = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 6;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("midstart_lat", n, 17);
    chk("midstart_q", cociente, 14);
    chk("midstart_r", residuo, 2);

    // Start accepted in the DONE cycle (back-to-back divide-by-zero).
    @(negedge clk);
    A = 16'd5; B = 16'd0; start = 1'b1;
    @(negedge clk);
    chk("b2b_first_done", done, 1);
    A = 16'd8; B = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_done", done, 1);
    chk("b2b_second_r", residuo, 8);
    chk("b2b_second_q", cociente, 16'hFFFF);
    @(negedge clk);
    chk("b2b_idle", done, 0);

    // Reset at CALC cycle 8 aborts with no done pulse.
    @(negedge clk);
    A = 16'd1000; B = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_c8", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", cociente, 0);
    chk("abort_r", residuo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dz", div_cero, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    check_vec("after_abort", vecs[4]);

    // Reset wins over start.
    @(negedge clk);
    rst = 1'b1; A = 16'd40; B = 16'd4; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    @(negedge clk);
    chk("rst_prio_busy2", busy, 0);

`ifdef DIVISOR_SIGNO_EN
    con_signo = 1'b1;
    check_vec("s_m7_2",   '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0});
    check_vec("s_min_m1", '{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0});
    check_vec("s_7_m2",   '{16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0});
    check_vec("s_div0",   '{16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1});
    con_signo = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 The port `rst` SHALL be an input, 1 bit wide, and SHALL be the synchronous, active-high reset.
REQ-004 The port `start` SHALL be an input, 1 bit wide, and SHALL request a division of A by B.
REQ-005 The port `A` SHALL be an input, 16 bits wide, and SHALL carry the dividend.
REQ-006 The port `B` SHALL be an input, 16 bits wide, and SHALL carry the divisor.
REQ-007 The port `cociente` SHALL be an output, 16 bits wide, and SHALL carry the registered quotient.
REQ-008 The port `residuo` SHALL be an output, 16 bits wide, and SHALL carry the registered remainder.
REQ-009 The port `busy` SHALL be an output, 1 bit wide, and SHALL be high while a division is in progress.
REQ-010 The port `done` SHALL be an output, 1 bit wide, and SHALL be a one-cycle pulse marking valid results.
REQ-011 The port `div_cero` SHALL be an output, 1 bit wide, and SHALL flag that the last result came from B == 0.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 IDLE SHALL transition to CALC when `start` = 1 and B != 0.
REQ-014 IDLE SHALL transition to DONE when `start` = 1 and B == 0.
REQ-015 CALC SHALL last exactly 16 cycles, then transition to DONE.
REQ-016 DONE SHALL last one cycle; DONE SHALL treat `start` exactly as IDLE does, otherwise it SHALL return to IDLE.
REQ-017 A and B SHALL be captured on the edge that accepts `start`; later input changes SHALL have no effect on the running division.
REQ-018 `start` SHALL be ignored while in CALC.
REQ-019 The divider SHALL use the restoring algorithm, producing one quotient bit per CALC cycle, MSB first, with a 17-bit partial remainder.
REQ-020 Latency SHALL be as follows: `done` = 1 in the 17th cycle after the accepting edge for B != 0, and in the 1st cycle after it for B == 0.
REQ-021 `busy` SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-022 `done` SHALL be 1 only in DONE.
REQ-023 `cociente`, `residuo` and `div_cero` SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-024 When B == 0, the results SHALL be `cociente` = 16'hFFFF, `residuo` = A and `div_cero` = 1.
REQ-025 When B != 0, `div_cero` SHALL be 0.
REQ-026 In unsigned mode, results SHALL satisfy A == cociente*B + residuo with residuo < B.

Reset
REQ-027 When `rst` = 1 at a clock edge, the block SHALL enter IDLE and clear `cociente`, `residuo`, `busy`, `done` and `div_cero` to 0.
REQ-028 `rst` SHALL take priority over `start`.
REQ-029 Reset during CALC SHALL abort the division with no `done` pulse.

Configuration
REQ-030 When macro DIVISOR_SIGNO_EN is defined, the block SHALL add port `con_signo` (input, 1 bit); `con_signo` = 1 SHALL select two's-complement operation.
REQ-031 Signed operation SHALL divide magnitudes unsigned and then correct signs.
REQ-032 Signed results SHALL truncate toward zero, and the sign of `residuo` SHALL follow A.
REQ-033 Signed -32768 / -1 SHALL give `cociente` = 16'h8000 and `residuo` = 0.
REQ-034 Signed division by zero SHALL give `cociente` = 16'hFFFF, `residuo` = A and `div_cero` = 1.
REQ-035 `con_signo` SHALL be captured together with A and B.
REQ-036 Sign correction SHALL add no cycles to the latency.
REQ-037 When DIVISOR_SIGNO_EN is undefined, the block SHALL have no `con_signo` port and SHALL operate unsigned only.

Structure
REQ-038 Package `divisor_pkg` SHALL contain ANCHO = 16, the state enumeration (IDLE, CALC, DONE), the 5-bit iteration-counter width, and COCIENTE_DIV_CERO = 16'hFFFF.
REQ-039 Sub-module `divisor_paso` SHALL be combinational and SHALL implement one restoring step: inputs are the partial remainder, the next dividend bit and the divisor; outputs are the new partial remainder and the quotient bit.
REQ-040 The top level SHALL hold the FSM, the counter, the operand registers and the output registers.

Verification
REQ-041 Unsigned A = 100, B = 7, `start` pulse: `busy` SHALL be high for 16 cycles, then `done` SHALL be high in cycle 17 with `cociente` = 14 and `residuo` = 2.
REQ-042 A = 16'hFFFF, B = 1: results SHALL be `cociente` = 16'hFFFF and `residuo` = 0; then A = 3, B = 16'hFFFF: results SHALL be `cociente` = 0 and `residuo` = 3.
REQ-043 A = 5, B = 0: `done` SHALL be high 1 cycle after start with `cociente` = 16'hFFFF, `residuo` = 5, `div_cero` = 1 and `busy` never high.
REQ-044 A second `start` with new A/B applied mid-CALC SHALL be ignored, and the first result SHALL be returned unchanged.
REQ-045 `rst` applied at CALC cycle 8 SHALL leave all outputs at 0 on the next cycle with no `done` pulse; a following start with A = 9, B = 3 SHALL give `cociente` = 3 and `residuo` = 0.
REQ-046 With DIVISOR_SIGNO_EN defined and `con_signo` = 1: A = -7, B = 2 SHALL give `cociente` = -3 and `residuo` = -1; A = -32768, B = -1 SHALL give `cociente` = 16'h8000 and `residuo` = 0.
